// File: rtl/spi_pkg.sv
// spi_pkg: shared definitions for the SPI master controller.
//   state_t / ST_* : FSM state encodings (IDLE, START, SHIFT, WAIT_RD, CAPTURE, GAP)
//   CMD_*          : command codes carried in cmd_data[9:8]
//   cnt_w()        : counter width helper
package spi_pkg;

  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE    = 3'd0;
  localparam state_t ST_START   = 3'd1;
  localparam state_t ST_SHIFT   = 3'd2;
  localparam state_t ST_WAIT_RD = 3'd3;
  localparam state_t ST_CAPTURE = 3'd4;
  localparam state_t ST_GAP     = 3'd5;

  localparam logic [1:0] CMD_WR_ADDR = 2'b00;
  localparam logic [1:0] CMD_WR_DATA = 2'b01;
  localparam logic [1:0] CMD_RD_ADDR = 2'b10;
  localparam logic [1:0] CMD_RD_DATA = 2'b11;

  // Width that holds the largest terminal count of any timed state.
  // The gap length is included so large GAP values cannot wrap the counter.
  function automatic int cnt_w(input int fw, input int rl, input int gp);
    int m;
    m = fw;
    if (rl > m) m = rl;
    if (gp > m) m = gp;
    return $clog2(m + 1);
  endfunction

endpackage

// File: rtl/spi_tx_shifter.sv
// spi_tx_shifter: one shift register used both ways. Parallel-loaded with the
// command word and shifted out MSB first; the same register shifts MISO in at
// the LSB so the reply byte assembles MSB first. Also holds the state counter.
//   clk, rst_n  clock / async active-low reset
//   load        parallel load of ld_data (wins over shift)
//   ld_data     command word
//   shift       shift left one place, sin enters at bit 0
//   sin         serial input (MISO during capture, 0 otherwise)
//   cnt_clr     clear counter (wins over cnt_inc)
//   cnt_inc     increment counter
//   sout        register MSB (MOSI source)
//   rx_next     low RW bits as they will be after the current shift
//   cnt         counter value
module spi_tx_shifter #(
  parameter int FW = 10,
  parameter int RW = 8,
  parameter int CW = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          load,
  input  logic [FW-1:0] ld_data,
  input  logic          shift,
  input  logic          sin,
  input  logic          cnt_clr,
  input  logic          cnt_inc,
  output logic          sout,
  output logic [RW-1:0] rx_next,
  output logic [CW-1:0] cnt
);

  logic [FW-1:0] sreg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)     sreg <= '0;
    else if (load)  sreg <= ld_data;
    else if (shift) sreg <= {sreg[FW-2:0], sin};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       cnt <= '0;
    else if (cnt_clr) cnt <= '0;
    else if (cnt_inc) cnt <= cnt + 1'b1;
  end

  assign sout    = sreg[FW-1];
  assign rx_next = {sreg[RW-2:0], sin};

endmodule

// File: rtl/spi_master_ctrl.sv
// spi_master_ctrl: SPI master that serialises {cmd[1:0], payload} command words
// onto SS_n/MOSI one bit per clk and, for read-data commands, captures the
// MISO reply byte and returns it as a one-cycle response.
//   clk, rst_n           clock / async active-low reset
//   cmd_valid/ready/data command port (ready only in IDLE)
//   rsp_valid/rsp_data   read reply, one-cycle pulse, data held until next capture
//   busy                 state != IDLE
//   SS_n, MOSI, MISO     SPI pins
//   err                  sticky sequence error
// Build option: SPI_MASTER_SEQ_CHK_EN enables command-order checking
// (01 only after 00, 11 only after 10); otherwise err is tied 0.
module spi_master_ctrl
  import spi_pkg::*;
#(
  parameter int ADDR_SIZE = 8,
  parameter int RD_LAT    = 2,
  parameter int GAP       = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 cmd_valid,
  output logic                 cmd_ready,
  input  logic [ADDR_SIZE+1:0] cmd_data,
  output logic                 rsp_valid,
  output logic [ADDR_SIZE-1:0] rsp_data,
  output logic                 busy,
  output logic                 SS_n,
  output logic                 MOSI,
  input  logic                 MISO,
  output logic                 err
);

  localparam int FW = ADDR_SIZE + 2;
  localparam int CW = cnt_w(FW, RD_LAT, GAP);

  state_t                 state, nxt;
  logic   [1:0]           cmd_q;
  logic                   load, shift, cnt_clr, cnt_inc, cap_last, seq_bad;
  logic                   sout;
  logic   [ADDR_SIZE-1:0] rx_next;
  logic   [CW-1:0]        cnt;

  spi_tx_shifter #(.FW(FW), .RW(ADDR_SIZE), .CW(CW)) u_shf (
    .clk     (clk),
    .rst_n   (rst_n),
    .load    (load),
    .ld_data (cmd_data),
    .shift   (shift),
    .sin     ((state == ST_CAPTURE) ? MISO : 1'b0),
    .cnt_clr (cnt_clr),
    .cnt_inc (cnt_inc),
    .sout    (sout),
    .rx_next (rx_next),
    .cnt     (cnt)
  );

  // Counter is cleared on every state change so each timed state counts from 0.
  always_comb begin
    nxt      = state;
    load     = 1'b0;
    shift    = 1'b0;
    cnt_clr  = 1'b0;
    cnt_inc  = 1'b1;
    cap_last = 1'b0;
    case (state)
      ST_IDLE: begin
        cnt_inc = 1'b0;
        if (cmd_valid && !seq_bad) begin
          load    = 1'b1;
          cnt_clr = 1'b1;
          nxt     = ST_START;
        end
      end
      ST_START: begin
        cnt_clr = 1'b1;
        nxt     = ST_SHIFT;
      end
      ST_SHIFT: begin
        shift = 1'b1;
        if (cnt == CW'(FW - 1)) begin
          cnt_clr = 1'b1;
          nxt     = (cmd_q == CMD_RD_DATA) ? ST_WAIT_RD : ST_GAP;
        end
      end
      ST_WAIT_RD: begin
        if (cnt == CW'(RD_LAT - 1)) begin
          cnt_clr = 1'b1;
          nxt     = ST_CAPTURE;
        end
      end
      ST_CAPTURE: begin
        shift = 1'b1;
        if (cnt == CW'(ADDR_SIZE - 1)) begin
          cap_last = 1'b1;
          cnt_clr  = 1'b1;
          nxt      = ST_GAP;
        end
      end
      ST_GAP: begin
        if (cnt == CW'(GAP - 1)) begin
          cnt_clr = 1'b1;
          nxt     = ST_IDLE;
        end
      end
      default: begin
        cnt_clr = 1'b1;
        nxt     = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      cmd_q     <= CMD_WR_ADDR;
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
    end else begin
      state     <= nxt;
      rsp_valid <= cap_last;
      if (load)     cmd_q    <= cmd_data[FW-1:FW-2];
      if (cap_last) rsp_data <= rx_next;
    end
  end

`ifdef SPI_MASTER_SEQ_CHK_EN
  logic [1:0] last_cmd;
  logic       last_vld, err_q;

  always_comb begin
    seq_bad = 1'b0;
    if (cmd_data[FW-1:FW-2] == CMD_WR_DATA)
      seq_bad = !(last_vld && last_cmd == CMD_WR_ADDR);
    else if (cmd_data[FW-1:FW-2] == CMD_RD_DATA)
      seq_bad = !(last_vld && last_cmd == CMD_RD_ADDR);
  end

  // Rejected commands are consumed in IDLE but do not update the history.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_cmd <= CMD_WR_ADDR;
      last_vld <= 1'b0;
      err_q    <= 1'b0;
    end else if (state == ST_IDLE && cmd_valid) begin
      if (seq_bad) err_q <= 1'b1;
      else begin
        last_cmd <= cmd_data[FW-1:FW-2];
        last_vld <= 1'b1;
      end
    end
  end

  assign err = err_q;
`else
  assign seq_bad = 1'b0;
  assign err     = 1'b0;
`endif

  assign cmd_ready = (state == ST_IDLE);
  assign busy      = (state != ST_IDLE);
  assign SS_n      = (state == ST_IDLE) || (state == ST_GAP);
  assign MOSI      = (state == ST_SHIFT) && sout;

endmodule

// File: tb/tb_spi_master_ctrl.sv
// tb_spi_master_ctrl: directed bench for spi_master_ctrl (default parameters).
// A negedge monitor measures SS_n low/high runs, collects MOSI bits and
// rsp_valid pulses, and plays back a MISO reply byte during the capture window.
module tb_spi_master_ctrl;

  localparam int RD_LAT = 2;
  localparam int GAP    = 1;
  localparam int CAP0   = 11 + RD_LAT;  // frame cycle index of first MISO sample

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  logic [9:0] cmd_data = '0;
  logic       rsp_valid;
  logic [7:0] rsp_data;
  logic       busy, SS_n, MOSI, err;
  logic       MISO = 1'b0;

  int tests = 0;
  int fails = 0;

  spi_master_ctrl #(.ADDR_SIZE(8), .RD_LAT(RD_LAT), .GAP(GAP)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_data  (cmd_data),
    .rsp_valid (rsp_valid),
    .rsp_data  (rsp_data),
    .busy      (busy),
    .SS_n      (SS_n),
    .MOSI      (MOSI),
    .MISO      (MISO),
    .err       (err)
  );

  always #5 clk = ~clk;

  // monitor state
  logic [7:0]  miso_byte = 8'h00;
  logic [31:0] mosi_bits = '0, last_mosi = '0;
  bit          in_frame = 1'b0;
  int          low_cnt = 0, last_low = 0, high_cnt = 0, last_high = 0;
  int          frames = 0, rsp_cnt = 0, rsp_run = 0, max_rsp_run = 0, both_cnt = 0;

  always @(negedge clk) begin
    if (!SS_n) begin
      if (!in_frame) begin
        in_frame  = 1'b1;
        last_high = high_cnt;
        low_cnt   = 0;
        mosi_bits = '0;
      end
      mosi_bits = {mosi_bits[30:0], MOSI};
      low_cnt++;
      if (low_cnt - 1 >= CAP0 && low_cnt - 1 < CAP0 + 8)
        MISO = miso_byte[7 - (low_cnt - 1 - CAP0)];
      else
        MISO = 1'b0;
    end else begin
      if (in_frame) begin
        in_frame  = 1'b0;
        last_low  = low_cnt;
        last_mosi = mosi_bits;
        frames++;
        high_cnt  = 0;
      end
      high_cnt++;
      MISO = 1'b0;
    end
    if (rsp_valid) begin
      rsp_cnt++;
      rsp_run++;
      if (rsp_run > max_rsp_run) max_rsp_run = rsp_run;
    end else rsp_run = 0;
    if (rsp_valid && cmd_ready) both_cnt++;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic send(input logic [9:0] c);
    bit ok = 1'b0;
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_data  = c;
    for (int i = 0; i < 200 && !ok; i++) begin
      if (cmd_ready) begin
        @(posedge clk);
        #1 cmd_valid = 1'b0;
        ok = 1'b1;
      end else @(negedge clk);
    end
    if (!ok) begin
      cmd_valid = 1'b0;
      chk("send_timeout", 32'd0, 32'd1);
    end
  endtask

  task automatic wait_idle();
    bit ok = 1'b0;
    for (int i = 0; i < 200 && !ok; i++) begin
      @(negedge clk);
      if (cmd_ready && SS_n) ok = 1'b1;
    end
    if (!ok) chk("idle_timeout", 32'd0, 32'd1);
  endtask

  int f0, r0, acc1, acc2;

  initial begin
    // 1 reset
    #23;
    chk("rst_ss_n", 32'(SS_n), 32'd1);
    chk("rst_mosi", 32'(MOSI), 32'd0);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_rsp_data", 32'(rsp_data), 32'h0);
    chk("rst_err", 32'(err), 32'd0);
    @(negedge clk) rst_n = 1'b1;
    @(negedge clk);
    chk("rst_cmd_ready", 32'(cmd_ready), 32'd1);
    chk("rst_busy", 32'(busy), 32'd0);

    // 2 write address 0xA5: START slot 0 then 00_1010_0101
    f0 = frames; r0 = rsp_cnt;
    send(10'h0A5);
    wait_idle();
    chk("wa_frames", 32'(frames - f0), 32'd1);
    chk("wa_low", 32'(last_low), 32'd11);
    chk("wa_mosi", last_mosi & 32'h7FF, 32'h0A5);
    chk("wa_no_rsp", 32'(rsp_cnt - r0), 32'd0);

    // 3 rd-addr then rd-data, reply 0x3C
    r0 = rsp_cnt;
    send(10'h212);
    wait_idle();
    chk("ra_low", 32'(last_low), 32'd11);
    chk("ra_mosi", last_mosi & 32'h7FF, 32'h212);
    chk("ra_no_rsp", 32'(rsp_cnt - r0), 32'd0);
    miso_byte = 8'h3C;
    send(10'h300);
    wait_idle();
    chk("rd_low", 32'(last_low), 32'd21);
    chk("rd_rsp_cnt", 32'(rsp_cnt - r0), 32'd1);
    chk("rd_rsp_width", 32'(max_rsp_run), 32'd1);
    chk("rd_rsp_data", 32'(rsp_data), 32'h3C);
    repeat (5) @(negedge clk);
    chk("rd_rsp_hold", 32'(rsp_data), 32'h3C);

    // 4 back-to-back with cmd_valid held: 00_5A then 01_33
    f0 = frames; acc1 = -1; acc2 = -1;
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_data  = 10'h05A;
    for (int i = 0; i < 100 && acc2 < 0; i++) begin
      if (cmd_ready) begin
        if (acc1 < 0) acc1 = i;
        else acc2 = i;
      end
      @(negedge clk);
      if (acc1 >= 0) cmd_data = 10'h133;
    end
    cmd_valid = 1'b0;
    wait_idle();
    // START + 10 SHIFT + GAP state + IDLE accept cycle
    chk("b2b_accept_spacing", 32'(acc2 - acc1), 32'(11 + GAP + 1));
    chk("b2b_frames", 32'(frames - f0), 32'd2);
    chk("b2b_ss_high", 32'(last_high), 32'(GAP + 1));
    chk("b2b_mosi2", last_mosi & 32'h7FF, 32'h133);

    // 5 reset at SHIFT bit 4 of a rd-data frame
    send(10'h281);
    wait_idle();
    r0 = rsp_cnt;
    miso_byte = 8'hFF;
    send(10'h381);
    @(negedge clk);          // START
    repeat (5) @(negedge clk); // SHIFT bit 4
    chk("mid_ss_low", 32'(SS_n), 32'd0);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_ss_n", 32'(SS_n), 32'd1);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_mosi", 32'(MOSI), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (30) @(negedge clk);
    chk("mid_no_rsp", 32'(rsp_cnt - r0), 32'd0);
    chk("mid_rsp_data", 32'(rsp_data), 32'h0);

    // 6 rd-data without prior rd-addr
    f0 = frames; r0 = rsp_cnt;
    miso_byte = 8'hA5;
    send(10'h344);
    wait_idle();
    repeat (3) @(negedge clk);
`ifdef SPI_MASTER_SEQ_CHK_EN
    chk("seq_frames", 32'(frames - f0), 32'd0);
    chk("seq_err", 32'(err), 32'd1);
    chk("seq_no_rsp", 32'(rsp_cnt - r0), 32'd0);
`else
    chk("seq_frames", 32'(frames - f0), 32'd1);
    chk("seq_low", 32'(last_low), 32'd21);
    chk("seq_rsp_data", 32'(rsp_data), 32'hA5);
    chk("seq_err", 32'(err), 32'd0);
`endif

    chk("rsp_ready_overlap", 32'(both_cnt), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
